// File: rtl/mem_stage_wb_latch.sv
// mem_stage_wb_latch
// ------------------
// MEM stage of the pipeline plus the MEM/WB pipeline latch.
//  - Branch resolution (pc_src) is combinational from the memory control bus
//    and the ALU zero flag.
//  - Data memory: mem_depth 32-bit words with byte-lane write enables. It is
//    written on the rising clock edge and read combinationally.
//  - The MEM/WB latch captures on the falling clock edge. This lets a load
//    that follows a store see the stored word, because the store was written
//    on the rising edge that came before.
//
// Ports
//   clk, reset        pipeline clock; asynchronous active-high reset
//   in_alu            byte address / ALU result
//   in_reg2           store data
//   in_pc_branch      branch target, passed straight to pc_branch_out
//   zero_flag         ALU zero flag
//   in_write_reg      destination register index
//   memory_bus        [0] rd, [1] wr, [2] beq, [3] bne, [5:4] size,
//                     [6] unsigned load, [7] jump, [8] unused
//   writeBack_bus     [0] reg_write, [1] mem_to_reg
//   halt_flag_m       halt marker, propagated only
//   debug_addr        word index for the debug read port
//   pc_src, pc_branch_out, out_mem_forw, out_wb_forw, debug_data
//                     combinational outputs
//   out_read_data, out_alu, out_write_reg, writeBack_bus_out,
//   out_halt_flag_m, out_misaligned
//                     MEM/WB latch outputs (falling edge)
module mem_stage_wb_latch #(
  parameter int len_data    = 32,
  parameter int num_bits    = 5,
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2,
  parameter int mem_depth   = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [len_data-1:0]          in_alu,
  input  logic [len_data-1:0]          in_reg2,
  input  logic [len_data-1:0]          in_pc_branch,
  input  logic                         zero_flag,
  input  logic [num_bits-1:0]          in_write_reg,
  input  logic [len_mem_bus-1:0]       memory_bus,
  input  logic [len_wb_bus-1:0]        writeBack_bus,
  input  logic                         halt_flag_m,
  input  logic [$clog2(mem_depth)-1:0] debug_addr,
  output logic                         pc_src,
  output logic [len_data-1:0]          pc_branch_out,
  output logic [len_data-1:0]          out_mem_forw,
  output logic [len_data-1:0]          out_wb_forw,
  output logic [len_data-1:0]          debug_data,
  output logic [len_data-1:0]          out_read_data,
  output logic [len_data-1:0]          out_alu,
  output logic [num_bits-1:0]          out_write_reg,
  output logic [len_wb_bus-1:0]        writeBack_bus_out,
  output logic                         out_halt_flag_m,
  output logic                         out_misaligned
);

  localparam int aw = $clog2(mem_depth);

  // Control bus decode
  logic       mem_read, mem_write, beq, bne, jump, mem_unsigned;
  logic [1:0] size;
  logic       is_byte, is_half, is_word;

  assign mem_read     = memory_bus[0];
  assign mem_write    = memory_bus[1];
  assign beq          = memory_bus[2];
  assign bne          = memory_bus[3];
  assign size         = memory_bus[5:4];
  assign mem_unsigned = memory_bus[6];
  assign jump         = memory_bus[7];

  assign is_byte = (size == 2'b00);
  assign is_half = (size == 2'b01);
  assign is_word = size[1];  // 2'b10 behaves as a word access

  // Reserved bus bit and the address bits above the word index do not
  // take part in any logic.
  logic unused_bits;
  assign unused_bits = ^{memory_bus[len_mem_bus-1:8], in_alu[len_data-1:aw+2]};

  // Branch resolution and pass-through outputs
  assign pc_src        = (beq & zero_flag) | (bne & ~zero_flag) | jump;
  assign pc_branch_out = in_pc_branch;
  assign out_mem_forw  = in_alu;

  // Address decode. The upper address bits are dropped, so the address
  // wraps modulo mem_depth words.
  logic [aw-1:0] word_idx;
  logic [1:0]    byte_lane;
  logic          misaligned;
  logic          access_mis;
  logic          store_en;

  assign word_idx   = in_alu[aw+1:2];
  assign byte_lane  = in_alu[1:0];
  assign misaligned = (is_half & byte_lane[0]) | (is_word & (byte_lane != 2'b00));
  assign access_mis = (mem_read | mem_write) & misaligned;
  assign store_en   = mem_write & ~misaligned;

  // Data memory. The array starts at all zeros and reset never clears it.
  logic [31:0] mem [mem_depth] = '{default: '0};

  // Per-lane write enable and write data. A half store replicates the low
  // halfword onto both halves; a byte store replicates the low byte onto
  // all lanes. The enables then pick the lanes that are actually written.
  logic [3:0]      lane_we;
  logic [3:0][7:0] wr_lane;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = store_en &
                         (is_word |
                          (is_half & (byte_lane[1] == (gi >= 2))) |
                          (is_byte & (byte_lane == 2'(gi))));
    assign wr_lane[gi] = is_byte ? in_reg2[7:0] :
                         is_half ? in_reg2[(gi % 2)*8 +: 8] :
                                   in_reg2[gi*8 +: 8];
  end

  // Stores are held off while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) begin
          mem[word_idx][i*8 +: 8] <= wr_lane[i];
        end
      end
    end
  end

  // Combinational load path: select the lane, then sign- or zero-extend.
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [len_data-1:0] load_data;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[byte_lane*8 +: 8];
  assign rd_half = byte_lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = '0;
    if (is_byte) begin
      load_data = mem_unsigned ? len_data'(rd_byte) : len_data'($signed(rd_byte));
    end else if (is_half) begin
      load_data = mem_unsigned ? len_data'(rd_half) : len_data'($signed(rd_half));
    end else begin
      load_data = mem_unsigned ? len_data'(rd_word) : len_data'($signed(rd_word));
    end
  end

  assign debug_data = len_data'(mem[debug_addr]);

  // MEM/WB latch
  logic [len_data-1:0]   read_data_d, read_data_q;
  logic [len_data-1:0]   alu_d, alu_q;
  logic [num_bits-1:0]   write_reg_d, write_reg_q;
  logic [len_wb_bus-1:0] wb_d, wb_q;
  logic                  halt_d, halt_q;
  logic                  mis_d, mis_q;

  always_comb begin
    // When read and write are both set, the access is treated as a store
    // only, so nothing is loaded.
    read_data_d = (mem_read & ~mem_write & ~misaligned) ? load_data : '0;
    alu_d       = in_alu;
    write_reg_d = in_write_reg;
    wb_d        = writeBack_bus;
    // A misaligned access must not write back to the register file.
    wb_d[0]     = writeBack_bus[0] & ~access_mis;
    halt_d      = halt_flag_m;
    mis_d       = access_mis;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      read_data_q <= '0;
      alu_q       <= '0;
      write_reg_q <= '0;
      wb_q        <= '0;
      halt_q      <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      alu_q       <= alu_d;
      write_reg_q <= write_reg_d;
      wb_q        <= wb_d;
      halt_q      <= halt_d;
      mis_q       <= mis_d;
    end
  end

  assign out_read_data     = read_data_q;
  assign out_alu           = alu_q;
  assign out_write_reg     = write_reg_q;
  assign writeBack_bus_out = wb_q;
  assign out_halt_flag_m   = halt_q;
  assign out_misaligned    = mis_q;
  assign out_wb_forw       = wb_q[1] ? read_data_q : alu_q;

endmodule

// File: tb/tb_mem_stage_wb_latch.sv
// Testbench for mem_stage_wb_latch. The driver applies one transaction per
// clock and queues the expected MEM/WB latch contents. The monitor pops one
// entry per rising edge, which falls half a cycle after the latching edge,
// and compares it. Combinational outputs are checked inline by the driver.
module tb_mem_stage_wb_latch;

  localparam logic [8:0] MR  = 9'h001;
  localparam logic [8:0] MW  = 9'h002;
  localparam logic [8:0] BEQ = 9'h004;
  localparam logic [8:0] BNE = 9'h008;
  localparam logic [8:0] SZB = 9'h000;
  localparam logic [8:0] SZH = 9'h010;
  localparam logic [8:0] SZW = 9'h030;
  localparam logic [8:0] UNS = 9'h040;
  localparam logic [8:0] JMP = 9'h080;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_alu, in_reg2, in_pc_branch;
  logic        zero_flag;
  logic [4:0]  in_write_reg;
  logic [8:0]  memory_bus;
  logic [1:0]  writeBack_bus;
  logic        halt_flag_m;
  logic [7:0]  debug_addr;
  logic        pc_src;
  logic [31:0] pc_branch_out, out_mem_forw, out_wb_forw, debug_data;
  logic [31:0] out_read_data, out_alu;
  logic [4:0]  out_write_reg;
  logic [1:0]  writeBack_bus_out;
  logic        out_halt_flag_m, out_misaligned;

  mem_stage_wb_latch dut (
    .clk(clk), .reset(reset),
    .in_alu(in_alu), .in_reg2(in_reg2), .in_pc_branch(in_pc_branch),
    .zero_flag(zero_flag), .in_write_reg(in_write_reg),
    .memory_bus(memory_bus), .writeBack_bus(writeBack_bus),
    .halt_flag_m(halt_flag_m), .debug_addr(debug_addr),
    .pc_src(pc_src), .pc_branch_out(pc_branch_out),
    .out_mem_forw(out_mem_forw), .out_wb_forw(out_wb_forw),
    .debug_data(debug_data), .out_read_data(out_read_data),
    .out_alu(out_alu), .out_write_reg(out_write_reg),
    .writeBack_bus_out(writeBack_bus_out),
    .out_halt_flag_m(out_halt_flag_m), .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [1:0]  wb;
    logic        halt;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".read_data"}, out_read_data, e.rd);
        chk({e.name, ".alu"},       out_alu, e.alu);
        chk({e.name, ".write_reg"}, 32'(out_write_reg), 32'(e.wr));
        chk({e.name, ".wb_bus"},    32'(writeBack_bus_out), 32'(e.wb));
        chk({e.name, ".halt"},      32'(out_halt_flag_m), 32'(e.halt));
        chk({e.name, ".misalign"},  32'(out_misaligned), 32'(e.mis));
        chk({e.name, ".wb_forw"},   out_wb_forw, e.wb[1] ? e.rd : e.alu);
        $display("[TB] xact %-14s rd=%h alu=%h wb=%b mis=%b", e.name,
                 out_read_data, out_alu, writeBack_bus_out, out_misaligned);
      end
    end
  end

  task automatic xact(input string nm, input logic [31:0] alu, input logic [31:0] reg2,
                      input logic [8:0] mb, input logic [1:0] wb, input logic [4:0] wr,
                      input logic halt, input logic zero, input logic [31:0] exp_rd,
                      input logic exp_mis, input logic exp_pc);
    exp_t e;
    logic [31:0] pcb;
    pcb = 32'h4000_0000 + alu;
    @(posedge clk);
    #1;
    in_alu        = alu;
    in_reg2       = reg2;
    in_pc_branch  = pcb;
    memory_bus    = mb;
    writeBack_bus = wb;
    in_write_reg  = wr;
    halt_flag_m   = halt;
    zero_flag     = zero;
    e.name = nm;
    e.rd   = exp_rd;
    e.alu  = alu;
    e.wr   = wr;
    e.wb   = {wb[1], wb[0] & ~exp_mis};
    e.halt = halt;
    e.mis  = exp_mis;
    exp_q.push_back(e);
    #1;
    chk({nm, ".pc_src"},   32'(pc_src), 32'(exp_pc));
    chk({nm, ".pc_br"},    pc_branch_out, pcb);
    chk({nm, ".mem_forw"}, out_mem_forw, alu);
  endtask

  task automatic dbg(input string nm, input logic [7:0] idx, input logic [31:0] exp);
    debug_addr = idx;
    #1;
    chk(nm, debug_data, exp);
    $display("[TB] debug %-14s addr=%0d data=%h", nm, idx, debug_data);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_regs_zero(input string nm);
    chk({nm, ".read_data"}, out_read_data, 32'h0);
    chk({nm, ".alu"},       out_alu, 32'h0);
    chk({nm, ".write_reg"}, 32'(out_write_reg), 32'h0);
    chk({nm, ".wb_bus"},    32'(writeBack_bus_out), 32'h0);
    chk({nm, ".halt"},      32'(out_halt_flag_m), 32'h0);
    chk({nm, ".misalign"},  32'(out_misaligned), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_alu = '0; in_reg2 = '0; in_pc_branch = '0; zero_flag = 1'b0;
    in_write_reg = '0; memory_bus = '0; writeBack_bus = '0;
    halt_flag_m = 1'b0; debug_addr = '0;
    #3;
    chk_regs_zero("reset_init");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //   name            alu           reg2          bus             wb     wr  h  z  exp_rd        mis pc
    xact("st_w_10",      32'h10,  32'hDEADBEEF, MW|SZW,         2'b00, 1,  0, 0, 32'h0,        0,  0);
    xact("ld_w_10",      32'h10,  32'h0,        MR|SZW,         2'b11, 2,  0, 0, 32'hDEADBEEF, 0,  0);
    dbg("dbg_w4_a", 8'd4, 32'hDEADBEEF);
    xact("clr_w_10",     32'h10,  32'h0,        MW|SZW,         2'b00, 3,  0, 0, 32'h0,        0,  0);
    xact("st_b_13",      32'h13,  32'h00000080, MW|SZB,         2'b00, 4,  0, 0, 32'h0,        0,  0);
    xact("ld_b_13_s",    32'h13,  32'h0,        MR|SZB,         2'b11, 5,  0, 0, 32'hFFFFFF80, 0,  0);
    xact("ld_b_13_u",    32'h13,  32'h0,        MR|SZB|UNS,     2'b11, 6,  0, 0, 32'h00000080, 0,  0);
    dbg("dbg_b4", 8'd4, 32'h80000000);
    xact("ld_h_11_mis",  32'h11,  32'h0,        MR|SZH,         2'b11, 7,  0, 0, 32'h0,        1,  0);
    xact("st_w_12_mis",  32'h12,  32'h12345678, MW|SZW,         2'b01, 8,  0, 0, 32'h0,        1,  0);
    xact("st_h_16_halt", 32'h16,  32'h0000BEEF, MW|SZH,         2'b00, 9,  1, 0, 32'h0,        0,  0);
    dbg("dbg_mis_st", 8'd4, 32'h80000000);
    xact("ld_h_16_u",    32'h16,  32'h0,        MR|SZH|UNS,     2'b11, 10, 0, 0, 32'h0000BEEF, 0,  0);
    xact("ld_h_16_s",    32'h16,  32'h0,        MR|SZH,         2'b11, 11, 0, 0, 32'hFFFFBEEF, 0,  0);
    xact("ld_w_14_alu",  32'h14,  32'h0,        MR|SZW,         2'b01, 12, 0, 0, 32'hBEEF0000, 0,  0);
    xact("rw_both_20",   32'h20,  32'h11223344, MR|MW|SZW,      2'b11, 13, 0, 0, 32'h0,        0,  0);
    xact("ld_w_20",      32'h20,  32'h0,        MR|SZW,         2'b11, 14, 0, 0, 32'h11223344, 0,  0);
    xact("ld_w_wrap",    32'h420, 32'h0,        MR|SZW,         2'b11, 15, 0, 0, 32'h11223344, 0,  0);
    xact("st_b_21",      32'h21,  32'h000000AA, MW|SZB,         2'b00, 16, 0, 0, 32'h0,        0,  0);
    xact("ld_w_20_b",    32'h20,  32'h0,        MR|SZW,         2'b11, 17, 0, 0, 32'h1122AA44, 0,  0);
    dbg("dbg_w8", 8'd8, 32'h1122AA44);
    xact("beq_z1",       32'h100, 32'h0,        BEQ,            2'b00, 18, 0, 1, 32'h0,        0,  1);
    xact("bne_z1",       32'h104, 32'h0,        BNE,            2'b00, 19, 0, 1, 32'h0,        0,  0);
    xact("bne_z0",       32'h108, 32'h0,        BNE,            2'b00, 20, 0, 0, 32'h0,        0,  1);
    xact("beq_z0",       32'h10C, 32'h0,        BEQ,            2'b00, 21, 0, 0, 32'h0,        0,  0);
    xact("jump",         32'h110, 32'h0,        JMP,            2'b00, 22, 0, 0, 32'h0,        0,  1);
    xact("ld_pre_rst",   32'h20,  32'h0,        MR|SZW,         2'b11, 31, 1, 0, 32'h1122AA44, 0,  0);
    drain();

    // Reset in mid-stream with a store to word 12 already presented.
    in_alu = 32'h30; in_reg2 = 32'h5A5A5A5A; memory_bus = MW | SZW;
    writeBack_bus = 2'b01; in_write_reg = 5'd9; halt_flag_m = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk_regs_zero("reset_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_regs_zero("reset_held");
    in_alu = '0; in_reg2 = '0; memory_bus = '0; writeBack_bus = '0;
    in_write_reg = '0; halt_flag_m = 1'b0;
    #1 reset = 1'b0;
    dbg("rst_mem_keep", 8'd12, 32'h0);

    xact("st_w_30_post", 32'h30,  32'hCAFEF00D, MW|SZW,         2'b00, 1,  0, 0, 32'h0,        0,  0);
    xact("ld_w_30_post", 32'h30,  32'h0,        MR|SZW,         2'b11, 2,  0, 0, 32'hCAFEF00D, 0,  0);
    xact("idle",         32'h0,   32'h0,        9'h000,         2'b00, 0,  0, 0, 32'h0,        0,  0);
    drain();
    dbg("dbg_w12_post", 8'd12, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_wb_latch.md
MEM_STAGE_WB_LATCH -- requirements
Module: mem_stage_wb_latch

Interface
REQ-001 The block SHALL have parameter len_data, default 32, datapath width.
REQ-002 The block SHALL have parameter num_bits, default 5, register-index width.
REQ-003 The block SHALL have parameter len_mem_bus, default 9, memory control bus width.
REQ-004 The block SHALL have parameter len_wb_bus, default 2, writeback control bus width.
REQ-005 The block SHALL have parameter mem_depth, default 256, data memory depth in 32-bit words; address index width = clog2(mem_depth).
REQ-006 The block SHALL have ports: clk  in  1  pipeline clock; reset  in  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have ports: in_alu  in  len_data  byte address / ALU result; in_reg2  in  len_data  store data; in_pc_branch  in  len_data  branch target; zero_flag  in  1  ALU zero.
REQ-008 The block SHALL have ports: in_write_reg  in  num_bits  destination register; memory_bus  in  len_mem_bus  memory control; writeBack_bus  in  len_wb_bus  writeback control; halt_flag_m  in  1  halt marker.
REQ-009 The block SHALL have port debug_addr  in  clog2(mem_depth)  debug word index.
REQ-010 The block SHALL have combinational outputs: pc_src  out  1  take branch/jump; pc_branch_out  out  len_data  = in_pc_branch; out_mem_forw  out  len_data  = in_alu; out_wb_forw  out  len_data  final writeback value; debug_data  out  len_data  memory word at debug_addr.
REQ-011 The block SHALL have registered outputs: out_read_data  len_data; out_alu  len_data; out_write_reg  num_bits; writeBack_bus_out  len_wb_bus; out_halt_flag_m  1; out_misaligned  1.

Function
REQ-012 memory_bus fields SHALL be: [0] mem_read, [1] mem_write, [2] beq, [3] bne, [5:4] size (00 byte, 01 half, 11 word, 10 treated as word), [6] unsigned load, [7] jump, [8] reserved/ignored.
REQ-013 writeBack_bus fields SHALL be: [0] reg_write, [1] mem_to_reg.
REQ-014 pc_src SHALL = (beq & zero_flag) | (bne & ~zero_flag) | jump, combinationally, same cycle.
REQ-015 Word index SHALL be in_alu[clog2(mem_depth)+1:2]; byte lane in_alu[1:0]; upper address bits ignored (wrap-around modulo mem_depth).
REQ-016 Misaligned SHALL mean half with in_alu[0]=1 or word with in_alu[1:0]!=0.
REQ-017 Stores SHALL write on posedge clk when mem_write=1 and not misaligned: byte writes lane in_alu[1:0] with in_reg2[7:0]; half writes lanes {1,0} or {3,2} with in_reg2[15:0]; word writes all lanes; unselected lanes unchanged.
REQ-018 Misaligned store SHALL leave memory unchanged.
REQ-019 Load data SHALL be read combinationally from the addressed word, lane-selected, then sign-extended (bit 6=0) or zero-extended (bit 6=1) to len_data.
REQ-020 The MEM/WB latch SHALL update on negedge clk: out_read_data <= load data if mem_read & ~mem_write & ~misaligned, else 0; out_alu <= in_alu; out_write_reg <= in_write_reg; writeBack_bus_out <= writeBack_bus; out_halt_flag_m <= halt_flag_m.
REQ-021 out_misaligned SHALL latch 1 on negedge when (mem_read|mem_write) & misaligned, else 0 (one-cycle pulse per offending access).
REQ-022 mem_read and mem_write both 1 SHALL be treated as store only; out_read_data latches 0.
REQ-023 Misaligned access SHALL force writeBack_bus_out[0] to 0 (no register write).
REQ-024 out_wb_forw SHALL = writeBack_bus_out[1] ? out_read_data : out_alu.
REQ-025 Store followed by load of same word in the next cycle SHALL return the stored value (write at posedge precedes next read).
REQ-026 debug_data SHALL reflect memory contents combinationally, including writes completed at the most recent posedge.
REQ-027 halt_flag_m SHALL NOT suppress stores; it only propagates.

Reset
REQ-028 On reset all registered outputs SHALL be 0 immediately and held until reset deasserts; pending stores while reset=1 SHALL be suppressed.
REQ-029 Data memory SHALL NOT be cleared by reset; it SHALL initialize to all-zero at time zero.

Verification
REQ-030 Store word 0xDEADBEEF at addr 0x10, then load word 0x10 -> out_read_data=0xDEADBEEF, out_wb_forw=0xDEADBEEF with mem_to_reg=1.
REQ-031 Store byte 0x80 at 0x13 over 0x00000000, signed load byte 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; debug_addr=4 -> 0x80000000.
REQ-032 Load half at 0x11 -> out_misaligned=1 for one cycle, out_read_data=0, writeBack_bus_out[0]=0; store word at 0x12 -> memory unchanged.
REQ-033 beq with zero_flag=1 -> pc_src=1, pc_branch_out=in_pc_branch; bne with zero_flag=1 -> pc_src=0; jump=1 -> pc_src=1.
REQ-034 Assert reset mid-stream with store pending -> all outputs 0 asynchronously, memory word unchanged, normal operation resumes after release.
